store_addr_buffer: RTL and testbench
====================================

// Module: store_addr_buffer
// PURPOSE
//  In-order buffer of pending stores; sits beside the load reservation station and produces its
//  address_neq_stores input. Entries are allocated at issue, filled with address/data by the store
//  RS, retired by commit, then drained to data memory one at a time. Each load address latched
//  from the RS address_check pulse is compared against every live store.
// PARAMETERS
//  DEPTH   4   number of store entries, power of two, >=2
//  TAG_W   6   ROB tag width; tag 0 means "no tag"
//  DATA_W  32  address and data width
// PORTS
//  clk             in   1       rising-edge clock
//  reset           in   1       asynchronous, active-high; clears all state
//  flush           in   1       sync; discard all uncommitted entries
//  alloc_valid     in   1       allocate a new tail entry this cycle
//  alloc_tag       in   TAG_W   ROB tag of the allocated store (non-zero)
//  alloc_ready     out  1       1 = buffer not full
//  fill_valid      in   1       store RS delivers address+data
//  fill_tag        in   TAG_W   tag of the entry being filled
//  fill_addr       in   DATA_W  effective store address
//  fill_data       in   DATA_W  store data
//  commit_valid    in   1       ROB commits a store
//  commit_tag      in   TAG_W   tag of the committing store
//  ld_check        in   1       load RS address_check pulse
//  ld_addr         in   DATA_W  load effective address (valid with ld_check)
//  address_neq_stores out 1     1 = latched load address matches no live store
//  mem_wr_req      out  1       write request to data memory
//  mem_wr_addr     out  DATA_W  write address
//  mem_wr_data     out  DATA_W  write data
//  mem_wr_ack      in   1       memory accepted the write
//  empty           out  1       no live entries
// BEHAVIOUR
//  Storage: circular array; head/tail pointers log2(DEPTH) bits, wrap modulo DEPTH; count 0..DEPTH.
//  Entry state: FREE -> PEND (no address) -> FILLED -> COMMITTED -> FREE (after ack).
//  Reset: all entries FREE, pointers/count 0; alloc_ready=1, empty=1, address_neq_stores=1,
//   mem_wr_req=0, mem_wr_addr=0, mem_wr_data=0, latched load address=0.
//  Alloc: alloc_valid && alloc_ready -> tail entry PEND with alloc_tag, tail++. alloc_valid while
//   full is ignored (issue stage must stall on alloc_ready). alloc_ready = (count != DEPTH), comb.
//  Alloc and drain-retire in the same cycle while full: retire frees slot next cycle only; alloc
//   still refused this cycle.
//  Fill: fill_valid updates the PEND entry whose tag == fill_tag; no match -> ignored. Fill
//   with tag equal to a same-cycle alloc_tag does not hit (entry not yet live).
//  Commit: commit_valid marks the oldest non-COMMITTED entry COMMITTED iff its tag == commit_tag and
//   it is FILLED; otherwise ignored (ROB guarantees order).
//  Drain FSM: IDLE / WRITE. IDLE: head entry COMMITTED -> drive mem_wr_addr/data from head, raise
//   mem_wr_req, go WRITE. WRITE: hold req/addr/data stable until mem_wr_ack; on ack free head,
//   head++, drop req, back to IDLE. Max one write per 2 cycles; req never drops without ack.
//  Flush: every PEND/FILLED entry -> FREE; COMMITTED entries and the drain FSM untouched; tail moves
//   to just past the youngest COMMITTED entry (== head when none); count adjusts. Flush has priority
//   over alloc/fill/commit in the same cycle; mem_wr_ack in that cycle is still honoured.
//  Load check: ld_check latches ld_addr into chk_addr (overwrites previous). address_neq_stores is
//   registered: each cycle = NOT any(live entry: PEND, or FILLED/COMMITTED with addr == chk_addr).
//   Full 32-bit compare, no byte masking. PEND is a conservative conflict. Value for a new
//   chk_addr appears 1 cycle after ld_check (RS samples it only after address_check drops).
//  empty = (count == 0), comb.
//  reset asserted mid-write: req drops immediately (async); pending write is lost by design.
// TESTING
//  1 reset, alloc tags 1..4 -> alloc_ready=0 after 4th; 5th alloc ignored, count stays 4.
//  2 alloc tag 5, fill addr 0x100 data 0xAA, commit 5 -> mem_wr_req with 0x100/0xAA; ack after 3
//    cycles -> req held 3 cycles, empty=1 the cycle after ack.
//  3 alloc tag 7 (no fill), ld_check addr 0x200 -> neq=0; fill 0x300 -> neq=1 next cycle;
//    ld_check 0x300 -> neq=0.
//  4 alloc 1,2,3; fill+commit 1; flush -> tags 2,3 gone, entry 1 still drains, alloc_ready=1.
//  5 wrap: 10 alloc/fill/commit/ack rounds with DEPTH=4 -> writes in order, no lost or dup entry.
//  6 assert reset while mem_wr_req=1 -> req=0 same cycle, neq=1, empty=1.

Source files
------------

// File: rtl/store_addr_buffer.sv
// In-order pending-store buffer: allocates at issue, fills from the store RS,
// marks entries committed in ROB order, drains them to data memory one at a
// time, and tells the load RS whether the latched load address is free of
// conflicts with any live store.
module store_addr_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              alloc_valid,
  input  logic [TAG_W-1:0]  alloc_tag,
  output logic              alloc_ready,
  input  logic              fill_valid,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [DATA_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              commit_valid,
  input  logic [TAG_W-1:0]  commit_tag,
  input  logic              ld_check,
  input  logic [DATA_W-1:0] ld_addr,
  output logic              address_neq_stores,
  output logic              mem_wr_req,
  output logic [DATA_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_wr_ack,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0]   CNT_ONE = 1;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {E_FREE, E_PEND, E_FILLED, E_COMMITTED} ent_t;
  typedef enum logic {D_IDLE, D_WRITE} drain_t;

  ent_t              st_q   [DEPTH];
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [DATA_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [PTR_W:0]    count_q;

  drain_t            drain_q, drain_d;
  logic              req_q;
  logic [DATA_W-1:0] wr_addr_q, wr_data_q;
  logic [DATA_W-1:0] chk_addr_q;
  logic              neq_q;

  logic              alloc_fire, start_wr, retire, commit_hit, conflict;
  logic              cm_found;
  logic [PTR_W-1:0]  cm_idx;
  logic [PTR_W:0]    n_comm;
  logic [PTR_W-1:0]  slot [DEPTH];

  assign alloc_ready        = (count_q != CNT_FULL);
  assign empty              = (count_q == '0);
  assign alloc_fire         = alloc_valid && alloc_ready && !flush;
  assign address_neq_stores = neq_q;
  assign mem_wr_req         = req_q;
  assign mem_wr_addr        = wr_addr_q;
  assign mem_wr_data        = wr_data_q;

  // Locate the oldest uncommitted entry, count committed ones, detect load conflicts
  always_comb begin
    n_comm   = '0;
    cm_found = 1'b0;
    cm_idx   = head_q;
    conflict = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot[i] = head_q + PTR_W'(i);
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!cm_found && ((PTR_W+1)'(i) < count_q) && st_q[slot[i]] != E_COMMITTED) begin
        cm_found = 1'b1;
        cm_idx   = slot[i];
      end
      if (st_q[i] == E_COMMITTED) n_comm = n_comm + CNT_ONE;
      if (st_q[i] == E_PEND) conflict = 1'b1;
      if ((st_q[i] == E_FILLED || st_q[i] == E_COMMITTED) && addr_q[i] == chk_addr_q)
        conflict = 1'b1;
    end
    commit_hit = commit_valid && !flush && cm_found &&
                 st_q[cm_idx] == E_FILLED && tag_q[cm_idx] == commit_tag;
  end

  // Drain FSM next-state: launch a write when the head is committed, retire on ack
  always_comb begin
    drain_d  = drain_q;
    start_wr = 1'b0;
    retire   = 1'b0;
    case (drain_q)
      D_IDLE: if (st_q[head_q] == E_COMMITTED) begin
        start_wr = 1'b1;
        drain_d  = D_WRITE;
      end
      D_WRITE: if (mem_wr_ack) begin
        retire  = 1'b1;
        drain_d = D_IDLE;
      end
    endcase
  end

  // Drain state and registered memory write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_q   <= D_IDLE;
      req_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      drain_q <= drain_d;
      if (start_wr) begin
        req_q     <= 1'b1;
        wr_addr_q <= addr_q[head_q];
        wr_data_q <= data_q[head_q];
      end else if (retire) begin
        req_q <= 1'b0;
      end
    end
  end

  // Entry lifecycle; each write source targets a slot in a state no other source touches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        st_q[i]   <= E_FREE;
        tag_q[i]  <= '0;
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (flush) begin
          if (st_q[i] == E_PEND || st_q[i] == E_FILLED) st_q[i] <= E_FREE;
        end else if (fill_valid && st_q[i] == E_PEND && tag_q[i] == fill_tag) begin
          st_q[i]   <= E_FILLED;
          addr_q[i] <= fill_addr;
          data_q[i] <= fill_data;
        end
      end
      if (alloc_fire) begin
        st_q[tail_q]  <= E_PEND;
        tag_q[tail_q] <= alloc_tag;
      end
      if (commit_hit) st_q[cm_idx] <= E_COMMITTED;
      if (retire) st_q[head_q] <= E_FREE;
    end
  end

  // Pointers and occupancy; committed entries form a prefix from head, so a
  // flush simply pulls tail back to head + number of committed entries
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (retire) head_q <= head_q + PTR_ONE;
      if (flush) begin
        tail_q  <= head_q + n_comm[PTR_W-1:0];
        count_q <= retire ? n_comm - CNT_ONE : n_comm;
      end else begin
        if (alloc_fire) tail_q <= tail_q + PTR_ONE;
        if (alloc_fire && !retire)      count_q <= count_q + CNT_ONE;
        else if (!alloc_fire && retire) count_q <= count_q - CNT_ONE;
      end
    end
  end

  // Load address latch and registered no-conflict flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_addr_q <= '0;
      neq_q      <= 1'b1;
    end else begin
      if (ld_check) chk_addr_q <= ld_addr;
      neq_q <= !conflict;
    end
  end

endmodule

// File: tb/tb_store_addr_buffer.sv
// Self-checking bench for store_addr_buffer: directed scenarios followed by a
// randomized operation mix, checked against a queue-based reference model.
module tb_store_addr_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        alloc_valid = 1'b0;
  logic [5:0]  alloc_tag = '0;
  logic        alloc_ready;
  logic        fill_valid = 1'b0;
  logic [5:0]  fill_tag = '0;
  logic [31:0] fill_addr = '0;
  logic [31:0] fill_data = '0;
  logic        commit_valid = 1'b0;
  logic [5:0]  commit_tag = '0;
  logic        ld_check = 1'b0;
  logic [31:0] ld_addr = '0;
  logic        address_neq_stores;
  logic        mem_wr_req;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ack = 1'b0;
  logic        empty;

  int tests = 0;
  int fails = 0;

  store_addr_buffer #(.DEPTH(4), .TAG_W(6), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_tag(alloc_tag), .alloc_ready(alloc_ready),
    .fill_valid(fill_valid), .fill_tag(fill_tag), .fill_addr(fill_addr), .fill_data(fill_data),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .ld_check(ld_check), .ld_addr(ld_addr), .address_neq_stores(address_neq_stores),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ack(mem_wr_ack), .empty(empty)
  );

  always #5 clk = ~clk;

  // Reference model: live stores oldest first; st 0=pending, 1=filled, 2=committed
  typedef struct {
    logic [5:0]  tag;
    int          st;
    logic [31:0] addr;
    logic [31:0] data;
  } ent_s;
  ent_s        mq[$];
  logic [31:0] m_chk = '0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_neq();
    foreach (mq[i]) if (mq[i].st == 0 || mq[i].addr == m_chk) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit tag_live(input logic [5:0] t);
    foreach (mq[i]) if (mq[i].tag == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_alloc(input logic [5:0] t);
    alloc_valid = 1'b1; alloc_tag = t;
    tick();
    alloc_valid = 1'b0;
    if (mq.size() < 4) mq.push_back('{tag: t, st: 0, addr: '0, data: '0});
  endtask

  task automatic model_fill(input logic [5:0] t, input logic [31:0] a, input logic [31:0] d);
    foreach (mq[i]) if (mq[i].st == 0 && mq[i].tag == t) begin
      mq[i].st = 1; mq[i].addr = a; mq[i].data = d;
    end
  endtask

  task automatic do_fill(input logic [5:0] t, input logic [31:0] a, input logic [31:0] d);
    fill_valid = 1'b1; fill_tag = t; fill_addr = a; fill_data = d;
    tick();
    fill_valid = 1'b0;
    model_fill(t, a, d);
  endtask

  task automatic do_commit(input logic [5:0] t);
    commit_valid = 1'b1; commit_tag = t;
    tick();
    commit_valid = 1'b0;
    foreach (mq[i]) if (mq[i].st != 2) begin
      if (mq[i].st == 1 && mq[i].tag == t) mq[i].st = 2;
      break;
    end
  endtask

  task automatic do_flush();
    ent_s keep[$];
    flush = 1'b1;
    tick();
    flush = 1'b0;
    foreach (mq[i]) if (mq[i].st == 2) keep.push_back(mq[i]);
    mq = keep;
  endtask

  task automatic do_ldchk(input logic [31:0] a);
    ld_check = 1'b1; ld_addr = a;
    tick();
    ld_check = 1'b0;
    m_chk = a;
  endtask

  task automatic check_status(input string name);
    check({name, "_ready"}, 32'(alloc_ready), 32'(mq.size() != 4));
    check({name, "_empty"}, 32'(empty), 32'(mq.size() == 0));
  endtask

  task automatic check_neq(input string name);
    tick();
    tick();
    check(name, 32'(address_neq_stores), 32'(model_neq()));
  endtask

  // Wait (bounded) for the head write, hold it for 'hold' cycles, then ack it
  task automatic drain_one(input int hold);
    int n = 0;
    logic [31:0] ea, ed;
    ea = mq[0].addr;
    ed = mq[0].data;
    while (!mem_wr_req && n < 10) begin tick(); n++; end
    check("wr_req_rise", 32'(mem_wr_req), 32'd1);
    if (!mem_wr_req) begin void'(mq.pop_front()); return; end
    check("wr_addr", mem_wr_addr, ea);
    check("wr_data", mem_wr_data, ed);
    for (int k = 0; k < hold; k++) begin
      tick();
      check("wr_req_hold", 32'(mem_wr_req), 32'd1);
      check("wr_addr_hold", mem_wr_addr, ea);
    end
    mem_wr_ack = 1'b1;
    tick();
    mem_wr_ack = 1'b0;
    void'(mq.pop_front());
    check("wr_req_drop", 32'(mem_wr_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  t;
    logic [31:0] a;
    int          op;

    // Reset values
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_ready", 32'(alloc_ready), 32'd1);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_neq", 32'(address_neq_stores), 32'd1);
    check("rst_req", 32'(mem_wr_req), 32'd0);
    check("rst_wr_addr", mem_wr_addr, 32'd0);
    check("rst_wr_data", mem_wr_data, 32'd0);

    // Fill to capacity, then an ignored alloc
    for (int i = 1; i <= 4; i++) begin
      do_alloc(6'(i));
      check_status("fill_up");
    end
    do_alloc(6'd5);
    check_status("alloc_full");
    do_flush();
    check_status("flush_all");

    // Single store through to memory with a 3-cycle ack delay
    do_alloc(6'd5);
    do_fill(6'd5, 32'h100, 32'hAA);
    do_commit(6'd5);
    drain_one(3);
    check_status("after_ack");

    // Load conflict tracking: pending, filled elsewhere, filled same address
    do_alloc(6'd7);
    do_ldchk(32'h200);
    check_neq("neq_pend");
    do_fill(6'd7, 32'h300, 32'h33);
    check_neq("neq_filled_other");
    do_ldchk(32'h300);
    check_neq("neq_filled_same");
    do_flush();
    check_neq("neq_after_flush");

    // Fill in the same cycle as the alloc of that tag does not hit
    alloc_valid = 1'b1; alloc_tag = 6'd9;
    fill_valid = 1'b1; fill_tag = 6'd9; fill_addr = 32'h400; fill_data = 32'h44;
    tick();
    alloc_valid = 1'b0; fill_valid = 1'b0;
    mq.push_back('{tag: 6'd9, st: 0, addr: '0, data: '0});
    do_commit(6'd9);
    for (int k = 0; k < 4; k++) tick();
    check("same_cycle_fill_no_write", 32'(mem_wr_req), 32'd0);
    do_flush();
    check_status("flush_tag9");

    // Flush keeps the committed entry, discards the rest
    do_alloc(6'd1); do_alloc(6'd2); do_alloc(6'd3);
    do_fill(6'd1, 32'h10, 32'h11);
    do_commit(6'd1);
    do_flush();
    check_status("flush_keep_commit");
    do_ldchk(32'h10);
    check_neq("neq_committed");
    do_ldchk(32'h20);
    check_neq("neq_flushed_gone");
    drain_one(0);
    check_status("flush_drained");

    // Pointer wrap: ten back-to-back store lifecycles
    for (int r = 0; r < 10; r++) begin
      t = 6'(r + 11);
      a = $urandom;
      do_alloc(t);
      do_fill(t, a, ~a);
      do_commit(t);
      drain_one(int'($urandom_range(0, 2)));
    end
    check_status("wrap_done");

    // Randomized operation mix
    for (int s = 0; s < 400; s++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 2) begin
        do t = 6'($urandom_range(1, 63)); while (tag_live(t));
        do_alloc(t);
      end else if (op <= 4) begin
        if (mq.size() > 0 && $urandom_range(0, 3) != 0) t = mq[$urandom_range(0, mq.size() - 1)].tag;
        else t = 6'($urandom_range(1, 63));
        do_fill(t, {28'h0, 4'($urandom_range(0, 7))} << 4, $urandom);
      end else if (op <= 6) begin
        t = 6'($urandom_range(1, 63));
        if ($urandom_range(0, 3) != 0)
          foreach (mq[i]) if (mq[i].st != 2) begin t = mq[i].tag; break; end
        do_commit(t);
      end else if (op == 7) begin
        do_ldchk({28'h0, 4'($urandom_range(0, 7))} << 4);
        check_neq("rand_neq");
      end else if (op == 8) begin
        if (mq.size() > 0 && mq[0].st == 2) drain_one(int'($urandom_range(0, 2)));
      end else begin
        if ($urandom_range(0, 3) == 0) do_flush();
        else tick();
      end
      check_status("rand");
    end
    do_flush();
    while (mq.size() > 0) drain_one(0);
    check_status("rand_end");

    // Asynchronous reset while a write is outstanding
    do_alloc(6'd20);
    do_fill(6'd20, 32'h500, 32'h55);
    do_commit(6'd20);
    tick(); tick();
    check("pre_reset_req", 32'(mem_wr_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_req", 32'(mem_wr_req), 32'd0);
    check("async_rst_neq", 32'(address_neq_stores), 32'd1);
    check("async_rst_empty", 32'(empty), 32'd1);
    mq.delete();
    m_chk = '0;
    tick();
    reset = 1'b0;
    tick();
    check_status("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
